dual_index_serializer: RTL and testbench

- Consumes the (h_flag, l_flag) index pairs produced by the dual priority encoder stage.
- Buffers each valid pair in a small FIFO.
- Emits the pair as a serial index stream on a valid/ready interface: high index first, then low index.
- Drops and counts "no-pair" codes; flags malformed pairs.

---
 rtl/dual_prior_pkg.sv | 21 ++
 rtl/pair_fifo.sv | 56 +++++
 rtl/dual_index_serializer.sv | 159 +++++++++++++++
 tb/tb_dual_index_serializer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_prior_pkg.sv
// Shared definitions for the dual priority encoder back end: index width,
// the no-pair code, the (h, l) pair record and the serializer state encoding.
package dual_prior_pkg;

  localparam int IDX_W = 4;

  // Code the encoder emits when fewer than two bits were set.
  localparam logic [IDX_W-1:0] NO_PAIR = '1;

  typedef struct packed {
    logic [IDX_W-1:0] h;
    logic [IDX_W-1:0] l;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_H = 2'd1,
    SEND_L = 2'd2
  } state_t;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO holding encoded index pairs. Pointers carry one extra MSB
// so that full and empty are distinguishable when the index bits match.
// The head entry is presented combinationally on dout.
module pair_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Advance read and write pointers on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Write the storage array; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; empty/full come from the pointers,
    // so stale data is never observed and the array maps to plain RAM/flops.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dual_index_serializer.sv
// Accepts (h, l) index pairs from the dual priority encoder, drops and counts
// no-pair codes, flags malformed pairs, buffers valid pairs and replays each
// one as two output beats: high index first, then low index (out_last=1).
module dual_index_serializer #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       h_flag,
  input  logic [IDX_W-1:0]       l_flag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic [2**IDX_W-1:0]    out_onehot,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   err_pair,
  output logic [$clog2(DEPTH):0] level
);

  import dual_prior_pkg::*;

  localparam logic [IDX_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  state_t               state_q;
  logic                 out_valid_q;
  logic [IDX_W-1:0]     out_idx_q;
  logic                 out_last_q;
  logic [IDX_W-1:0]     low_q;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic                 err_q, err_d;

  logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [2*IDX_W-1:0]   fifo_dout;
  logic [IDX_W-1:0]     head_h, head_l;
  logic                 accept, is_no_pair, is_malformed;

  assign in_ready     = !fifo_full;
  assign accept       = in_valid && !fifo_full;
  assign is_no_pair   = (h_flag == ALL_ONES) && (l_flag == ALL_ONES);
  assign is_malformed = !is_no_pair && (h_flag <= l_flag);
  assign fifo_push    = accept && (h_flag > l_flag);
  assign head_h       = fifo_dout[2*IDX_W-1:IDX_W];
  assign head_l       = fifo_dout[IDX_W-1:0];

  pair_fifo #(
    .WIDTH (2*IDX_W),
    .DEPTH (DEPTH)
  ) u_pair_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({h_flag, l_flag}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Pop whenever the output register is free or its low beat is leaving.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    fifo_pop = 1'b0;
    case (state_q)
      IDLE:    fifo_pop = !fifo_empty;
      SEND_L:  fifo_pop = out_ready && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  // Saturating drop counter and sticky malformed flag next-state.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q;
    if (accept && is_no_pair && (drop_cnt_q != CNT_MAX)) drop_cnt_d = drop_cnt_q + CNT_ONE;
    if (accept && is_malformed) err_d = 1'b1;
  end

  // Register the drop counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  // Serializer FSM with registered outputs; frozen while a beat is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      low_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            out_idx_q   <= head_h;
            low_q       <= head_l;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= SEND_H;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        SEND_H: begin
          if (out_ready) begin
            out_idx_q  <= low_q;
            out_last_q <= 1'b1;
            state_q    <= SEND_L;
          end
        end
        SEND_L: begin
          if (out_ready) begin
            if (!fifo_empty) begin
              out_idx_q  <= head_h;
              low_q      <= head_l;
              out_last_q <= 1'b0;
              state_q    <= SEND_H;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // One-hot decode of the current index, masked by out_valid.
  always_comb begin
    out_onehot = '0;
    if (out_valid_q) out_onehot[out_idx_q] = 1'b1;
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_pair  = err_q;

endmodule

// File: tb/tb_dual_index_serializer.sv
// Self-checking bench for dual_index_serializer. A queue-based reference model
// tracks buffered pairs and the pair currently on the output; output beats
// seen on the DUT handshake are compared against the expected beat stream.
module tb_dual_index_serializer;
  import dual_prior_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  h_flag = 4'd0;
  logic [3:0]  l_flag = 4'd0;
  logic        in_ready, out_valid, out_last, err_pair;
  logic [3:0]  out_idx;
  logic [15:0] out_onehot;
  logic [7:0]  drop_cnt;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  // Reference model state
  pair_t      mq[$];
  bit         m_vld, m_low;
  pair_t      m_cur;
  int         m_drop;
  bit         m_err;
  logic [4:0] obs[$];
  logic [4:0] exp_beats[$];

  dual_index_serializer #(.DEPTH(DEPTH), .IDX_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .h_flag(h_flag), .l_flag(l_flag), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .out_onehot(out_onehot),
    .drop_cnt(drop_cnt), .err_pair(err_pair), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] m_idx();
    return m_low ? m_cur.l : m_cur.h;
  endfunction

  function automatic void exp_pair(input logic [3:0] h, input logic [3:0] l);
    exp_beats.push_back({1'b0, h});
    exp_beats.push_back({1'b1, l});
  endfunction

  // -1 when streams agree, -2 on length mismatch, else first differing index
  function automatic int stream_diff();
    if (obs.size() != exp_beats.size()) return -2;
    foreach (obs[i]) if (obs[i] !== exp_beats[i]) return i;
    return -1;
  endfunction

  function automatic pair_t gen_valid();
    pair_t p;
    p.h = 4'($urandom_range(1, 15));
    p.l = 4'($urandom_range(0, int'(p.h) - 1));
    return p;
  endfunction

  task automatic model_clear();
    mq.delete(); obs.delete(); exp_beats.delete();
    m_vld = 1'b0; m_low = 1'b0; m_cur = '0; m_drop = 0; m_err = 1'b0;
  endtask

  // One clock edge of the reference behaviour, from the inputs just driven.
  task automatic model_step(input bit iv, input logic [3:0] h, input logic [3:0] l,
                            input bit ordy, output bit acc);
    pair_t p;
    acc = iv && (mq.size() < DEPTH);
    if (!m_vld) begin
      if (mq.size() != 0) begin m_cur = mq.pop_front(); m_vld = 1'b1; m_low = 1'b0; end
    end else if (ordy) begin
      if (!m_low) m_low = 1'b1;
      else if (mq.size() != 0) begin m_cur = mq.pop_front(); m_low = 1'b0; end
      else m_vld = 1'b0;
    end
    if (acc) begin
      if (h == NO_PAIR && l == NO_PAIR) begin
        if (m_drop < CNT_MAX) m_drop++;
      end else if (h <= l) begin
        m_err = 1'b1;
      end else begin
        p.h = h; p.l = l;
        mq.push_back(p);
      end
    end
  endtask

  task automatic cycle(input bit iv, input logic [3:0] h, input logic [3:0] l,
                       input bit ordy, output bit acc);
    @(negedge clk);
    in_valid = iv; h_flag = h; l_flag = l; out_ready = ordy;
    #1;
    if (out_valid && out_ready) obs.push_back({out_last, out_idx});
    @(posedge clk);
    model_step(iv, h, l, ordy, acc);
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0, ordy, acc);
  endtask

  task automatic drain(output bit done);
    bit acc;
    for (int i = 0; i < 200 && (m_vld || mq.size() != 0); i++) cycle(1'b0, 4'd0, 4'd0, 1'b1, acc);
    done = !m_vld && (mq.size() == 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; h_flag = 4'd0; l_flag = 4'd0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({out_valid, out_idx, out_last, drop_cnt, err_pair, in_ready, level, out_onehot} !==
        {1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_values: got v=%b idx=%0d last=%b drop=%0d err=%b rdy=%b lvl=%0d oh=%h, want v=0 idx=0 last=0 drop=0 err=0 rdy=1 lvl=0 oh=0000",
               out_valid, out_idx, out_last, drop_cnt, err_pair, in_ready, level, out_onehot);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_pair();
    bit acc;
    apply_reset();
    cycle(1'b1, 4'd12, 4'd3, 1'b1, acc);
    checks++;
    if ({out_valid, level} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL single_push: got v=%b lvl=%0d, want v=0 lvl=1", out_valid, level);
    end
    cycle(1'b0, 4'd0, 4'd0, 1'b1, acc);
    checks++;
    if ({out_valid, out_idx, out_last, out_onehot} !== {1'b1, 4'd12, 1'b0, 16'h1000}) begin
      errors++; $display("FAIL single_high: got v=%b idx=%0d last=%b oh=%h, want v=1 idx=12 last=0 oh=1000",
                         out_valid, out_idx, out_last, out_onehot);
    end
    cycle(1'b0, 4'd0, 4'd0, 1'b1, acc);
    checks++;
    if ({out_valid, out_idx, out_last, out_onehot} !== {1'b1, 4'd3, 1'b1, 16'h0008}) begin
      errors++; $display("FAIL single_low: got v=%b idx=%0d last=%b oh=%h, want v=1 idx=3 last=1 oh=0008",
                         out_valid, out_idx, out_last, out_onehot);
    end
    cycle(1'b0, 4'd0, 4'd0, 1'b1, acc);
    checks++;
    if ({out_valid, out_onehot} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL single_done: got v=%b oh=%h, want v=0 oh=0000", out_valid, out_onehot);
    end
  endtask

  task automatic test_no_pair();
    bit acc;
    int seen_valid = 0;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 4'hF, 4'hF, 1'b1, acc);
      if (out_valid) seen_valid++;
    end
    checks++;
    if (drop_cnt !== 8'(m_drop)) begin
      errors++; $display("FAIL nopair_drop: got %0d want %0d", drop_cnt, m_drop);
    end
    checks++;
    if (seen_valid != 0) begin
      errors++; $display("FAIL nopair_out: out_valid seen %0d cycles, want 0", seen_valid);
    end
    checks++;
    if ({err_pair, level} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL nopair_err: got err=%b lvl=%0d, want err=0 lvl=0", err_pair, level);
    end
  endtask

  task automatic test_malformed();
    bit acc, done;
    int d;
    pair_t p;
    apply_reset();
    cycle(1'b1, 4'd2, 4'd7, 1'b1, acc);
    idle(3, 1'b1);
    checks++;
    if ({err_pair, out_valid, level} !== {1'b1, 1'b0, 3'd0} || obs.size() != 0) begin
      errors++; $display("FAIL malformed_flag: got err=%b v=%b lvl=%0d beats=%0d, want err=1 v=0 lvl=0 beats=0",
                         err_pair, out_valid, level, obs.size());
    end
    for (int i = 0; i < 10; i++) begin
      p = gen_valid();
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) cycle(1'b1, p.h, p.l, 1'($urandom_range(0, 1)), acc);
      if (acc) exp_pair(p.h, p.l);
    end
    drain(done);
    checks++;
    if (!done) begin errors++; $display("FAIL malformed_drain: output did not go idle"); end
    d = stream_diff();
    checks++;
    if (d != -1) begin
      errors++; $display("FAIL malformed_stream: diff=%0d got_beats=%0d want_beats=%0d", d, obs.size(), exp_beats.size());
    end
    checks++;
    if (err_pair !== 1'b1) begin errors++; $display("FAIL malformed_sticky: got %b want 1", err_pair); end
  endtask

  task automatic test_backpressure();
    bit acc;
    int d;
    logic [3:0] ph[6] = '{4'd15, 4'd9, 4'd5, 4'd4, 4'd3, 4'd7};
    logic [3:0] pl[6] = '{4'd0,  4'd8, 4'd1, 4'd2, 4'd0, 4'd6};
    apply_reset();
    // The first pair moves straight into the output register, so the FIFO
    // fills with pairs two to five and the sixth is refused.
    for (int i = 0; i < 6; i++) cycle(1'b1, ph[i], pl[i], 1'b0, acc);
    for (int i = 0; i < 5; i++) exp_pair(ph[i], pl[i]);
    checks++;
    if ({level, in_ready} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL bp_full: got lvl=%0d rdy=%b, want lvl=4 rdy=0", level, in_ready);
    end
    idle(3, 1'b0);
    checks++;
    if ({out_valid, out_idx, out_last} !== {1'b1, 4'd15, 1'b0}) begin
      errors++; $display("FAIL bp_hold: got v=%b idx=%0d last=%b, want v=1 idx=15 last=0", out_valid, out_idx, out_last);
    end
    idle(10, 1'b1);
    checks++;
    if (obs.size() != 10) begin
      errors++; $display("FAIL bp_nobubble: got %0d beats in 10 cycles, want 10", obs.size());
    end
    d = stream_diff();
    checks++;
    if (d != -1) begin
      errors++; $display("FAIL bp_stream: diff=%0d got_beats=%0d want_beats=%0d", d, obs.size(), exp_beats.size());
    end
    idle(1, 1'b1);
    checks++;
    if ({out_valid, level, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
      errors++; $display("FAIL bp_empty: got v=%b lvl=%0d rdy=%b, want v=0 lvl=0 rdy=1", out_valid, level, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, done;
    int d;
    pair_t p[4];
    apply_reset();
    for (int i = 0; i < 4; i++) begin p[i] = gen_valid(); exp_pair(p[i].h, p[i].l); end
    for (int i = 0; i < 3; i++) cycle(1'b1, p[i].h, p[i].l, 1'b1, acc);
    checks++;
    if ({level, out_valid, out_last, out_idx} !== {3'd2, 1'b1, 1'b1, p[0].l}) begin
      errors++; $display("FAIL b2b_setup: got lvl=%0d v=%b last=%b idx=%0d, want lvl=2 v=1 last=1 idx=%0d",
                         level, out_valid, out_last, out_idx, p[0].l);
    end
    cycle(1'b1, p[3].h, p[3].l, 1'b1, acc);
    checks++;
    if ({level, out_valid, out_last, out_idx} !== {3'd2, 1'b1, 1'b0, p[1].h}) begin
      errors++; $display("FAIL b2b_pushpop: got lvl=%0d v=%b last=%b idx=%0d, want lvl=2 v=1 last=0 idx=%0d",
                         level, out_valid, out_last, out_idx, p[1].h);
    end
    drain(done);
    d = stream_diff();
    checks++;
    if (!done || d != -1) begin
      errors++; $display("FAIL b2b_stream: done=%b diff=%0d got_beats=%0d want_beats=%0d", done, d, obs.size(), exp_beats.size());
    end
  endtask

  task automatic test_reset_midstream();
    bit acc;
    pair_t p;
    apply_reset();
    for (int i = 0; i < 3; i++) begin p = gen_valid(); cycle(1'b1, p.h, p.l, 1'b0, acc); end
    checks++;
    if ({out_valid, out_last, level} !== {1'b1, 1'b0, 3'd2}) begin
      errors++; $display("FAIL midrst_setup: got v=%b last=%b lvl=%0d, want v=1 last=0 lvl=2", out_valid, out_last, level);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({out_valid, out_idx, out_last, drop_cnt, err_pair, in_ready, level, out_onehot} !==
        {1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 16'd0}) begin
      errors++;
      $display("FAIL midrst_async: got v=%b idx=%0d last=%b drop=%0d err=%b rdy=%b lvl=%0d oh=%h, want v=0 idx=0 last=0 drop=0 err=0 rdy=1 lvl=0 oh=0000",
               out_valid, out_idx, out_last, drop_cnt, err_pair, in_ready, level, out_onehot);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b1);
    checks++;
    if ({in_ready, level, out_valid} !== {1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL midrst_release: got rdy=%b lvl=%0d v=%b, want rdy=1 lvl=0 v=0", in_ready, level, out_valid);
    end
  endtask

  task automatic test_random();
    bit acc, done, iv, ordy, is_valid;
    int d, kind;
    logic [3:0] h, l;
    logic [15:0] exp_oh;
    pair_t p;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      is_valid = 1'b0;
      if (kind == 0) begin h = 4'hF; l = 4'hF; end
      else if (kind == 1) begin h = 4'($urandom_range(0, 14)); l = 4'($urandom_range(int'(h), 14)); end
      else begin p = gen_valid(); h = p.h; l = p.l; is_valid = 1'b1; end
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(iv, h, l, ordy, acc);
      if (acc && is_valid) exp_pair(h, l);
      exp_oh = m_vld ? (16'd1 << m_idx()) : 16'd0;
      checks++;
      if ({in_ready, level, out_valid, out_onehot} !== {mq.size() < DEPTH, 3'(mq.size()), m_vld, exp_oh} ||
          (m_vld && {out_idx, out_last} !== {m_idx(), m_low})) begin
        errors++;
        $display("FAIL rand_cycle%0d: got rdy=%b lvl=%0d v=%b idx=%0d last=%b oh=%h, want rdy=%b lvl=%0d v=%b idx=%0d last=%b oh=%h",
                 i, in_ready, level, out_valid, out_idx, out_last, out_onehot,
                 mq.size() < DEPTH, mq.size(), m_vld, m_idx(), m_low, exp_oh);
      end
    end
    drain(done);
    d = stream_diff();
    checks++;
    if (!done || d != -1) begin
      errors++; $display("FAIL rand_stream: done=%b diff=%0d got_beats=%0d want_beats=%0d", done, d, obs.size(), exp_beats.size());
    end
    checks++;
    if ({drop_cnt, err_pair} !== {8'(m_drop), m_err}) begin
      errors++; $display("FAIL rand_status: got drop=%0d err=%b, want drop=%0d err=%b", drop_cnt, err_pair, m_drop, m_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_no_pair();
    test_malformed();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
